// File: rtl/rf_mp_scoreboard.sv
// rf_mp_scoreboard
//   General-purpose register file for the pipelined MIPS core. It has NR_RD
//   combinational read ports and two write ports: port 0 for ALU writeback
//   and port 1 for MEM writeback. Same-cycle writes are bypassed to the read
//   ports, and register 0 is hardwired to zero. After reset a sequencer clears
//   every entry, one per cycle. A per-register busy scoreboard lets the hazard
//   unit stall on outstanding loads.
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   rd_addr_i     NR_RD packed read addresses (port i at [i*ADDR_W +: ADDR_W])
//   rd_data_o     NR_RD packed read data      (port i at [i*DATA_W +: DATA_W])
//   rd_busy_o     busy bit of each read address, masked by same-cycle writes
//   we0_i/wa0_i/wd0_i   ALU writeback port
//   we1_i/wa1_i/wd1_i   MEM writeback port (wins over port 0 on same address)
//   rsv_en_i/rsv_addr_i mark a register busy (outstanding load)
//   ready_o       high once the clear sequence has finished
module rf_mp_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NR_RD  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NR_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NR_RD*DATA_W-1:0] rd_data_o,
    output logic [NR_RD-1:0]        rd_busy_o,
    input  logic                    we0_i,
    input  logic [ADDR_W-1:0]       wa0_i,
    input  logic [DATA_W-1:0]       wd0_i,
    input  logic                    we1_i,
    input  logic [ADDR_W-1:0]       wa1_i,
    input  logic [DATA_W-1:0]       wd1_i,
    input  logic                    rsv_en_i,
    input  logic [ADDR_W-1:0]       rsv_addr_i,
    output logic                    ready_o
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {S_CLEAR, S_RUN} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   clr_idx_q;
    logic                ready_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic                run;

    assign run     = (state_q == S_RUN);
    assign ready_o = ready_q;

    // Clear sequencer: walks clr_idx over every entry, then parks in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == ADDR_W'(DEPTH-1)) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN:   ready_q <= 1'b1;
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    // Storage has no reset; the sequencer zeroes it. Port 1 is written last
    // so it wins when both ports target the same register.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem_q[clr_idx_q] <= '0;
        end else begin
            if (we0_i && wa0_i != '0) mem_q[wa0_i] <= wd0_i;
            if (we1_i && wa1_i != '0) mem_q[wa1_i] <= wd1_i;
        end
    end

    // Scoreboard: a new reservation beats a same-cycle completing write.
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            for (int r = 1; r < DEPTH; r++) begin
                if (rsv_en_i && rsv_addr_i == ADDR_W'(r))
                    busy_d[r] = 1'b1;
                else if ((we0_i && wa0_i == ADDR_W'(r)) || (we1_i && wa1_i == ADDR_W'(r)))
                    busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    // Read ports. A write landing this cycle is both bypassed and unmasks
    // busy, so a bypassed value is never reported busy.
    for (genvar i = 0; i < NR_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              hit0, hit1, zero;
        assign a    = rd_addr_i[i*ADDR_W +: ADDR_W];
        assign hit0 = we0_i && (wa0_i == a);
        assign hit1 = we1_i && (wa1_i == a);
        assign zero = !run || (a == '0);
        assign rd_data_o[i*DATA_W +: DATA_W] = zero ? '0 :
                                               hit1 ? wd1_i :
                                               hit0 ? wd0_i : mem_q[a];
        assign rd_busy_o[i] = !zero && busy_q[a] && !(hit0 || hit1);
    end

endmodule

// File: tb/tb_rf_mp_scoreboard.sv
// Testbench for rf_mp_scoreboard: expected read results are queued as
// stimulus is driven and popped when the combinational outputs are sampled.
module tb_rf_mp_scoreboard;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NR_RD  = 2;
    localparam int DEPTH  = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NR_RD*ADDR_W-1:0] rd_addr;
    logic [NR_RD*DATA_W-1:0] rd_data;
    logic [NR_RD-1:0]        rd_busy;
    logic                    we0, we1, rsv_en, ready;
    logic [ADDR_W-1:0]       wa0, wa1, rsv_addr;
    logic [DATA_W-1:0]       wd0, wd1;

    rf_mp_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NR_RD(NR_RD)) dut (
        .clk(clk), .rst(rst),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0),
        .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .ready_o(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        busy;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic idle();
        we0 = 0; wa0 = '0; wd0 = '0;
        we1 = 0; wa1 = '0; wd1 = '0;
        rsv_en = 0; rsv_addr = '0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic push(input int p, input logic [31:0] d, input logic b, input string n);
        exp_t e;
        e.port = p; e.data = d; e.busy = b; e.name = n;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1; idle(); set_rd(0, 0); set_rd(1, 0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready: got %b want 0", ready);
        end
        @(negedge clk); rst = 0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (k > 1) @(negedge clk);
            // Writes and reservations during CLEAR must be ignored.
            we0 = 1; wa0 = 5'd3; wd0 = 32'hA000_0000 + k;
            rsv_en = 1; rsv_addr = 5'd4;
            set_rd(0, 3); set_rd(1, 4);
            push(0, 32'h0, 1'b0, "clear_rd0");
            push(1, 32'h0, 1'b0, "clear_rd1");
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); checks++;
                if (rd_data[e.port*DATA_W +: DATA_W] !== e.data || rd_busy[e.port] !== e.busy) begin
                    failures++;
                    $display("FAIL %s: port%0d data=%h busy=%b, want data=%h busy=%b", e.name, e.port,
                             rd_data[e.port*DATA_W +: DATA_W], rd_busy[e.port], e.data, e.busy);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (ready !== (k == DEPTH)) begin
                failures++; $display("FAIL clear_ready k=%0d: got %b want %b", k, ready, k == DEPTH);
            end
        end
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk); idle();
            set_rd(0, a); set_rd(1, DEPTH - 1 - a);
            push(0, 32'h0, 1'b0, "post_clear_rd0");
            push(1, 32'h0, 1'b0, "post_clear_rd1");
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); checks++;
                if (rd_data[e.port*DATA_W +: DATA_W] !== e.data || rd_busy[e.port] !== e.busy) begin
                    failures++;
                    $display("FAIL %s a=%0d: port%0d data=%h busy=%b, want data=%h busy=%b", e.name, a, e.port,
                             rd_data[e.port*DATA_W +: DATA_W], rd_busy[e.port], e.data, e.busy);
                end
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); idle();
            if (c == 0) begin we0 = 1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; end
            set_rd(0, 5); set_rd(1, 0);
            push(0, 32'hDEADBEEF, 1'b0, c == 0 ? "bypass_same_cycle" : "bypass_persist");
            push(1, 32'h0, 1'b0, "bypass_rd1_zero");
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); checks++;
                if (rd_data[e.port*DATA_W +: DATA_W] !== e.data || rd_busy[e.port] !== e.busy) begin
                    failures++;
                    $display("FAIL %s: port%0d data=%h busy=%b, want data=%h busy=%b", e.name, e.port,
                             rd_data[e.port*DATA_W +: DATA_W], rd_busy[e.port], e.data, e.busy);
                end
            end
        end
    endtask

    task automatic test_dual_write();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); idle();
            if (c == 0) begin
                we0 = 1; wa0 = 5'd7; wd0 = 32'h11;
                we1 = 1; wa1 = 5'd7; wd1 = 32'h22;
            end
            set_rd(0, 7); set_rd(1, 7);
            push(0, 32'h22, 1'b0, c == 0 ? "dual_bypass0" : "dual_stored0");
            push(1, 32'h22, 1'b0, c == 0 ? "dual_bypass1" : "dual_stored1");
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); checks++;
                if (rd_data[e.port*DATA_W +: DATA_W] !== e.data || rd_busy[e.port] !== e.busy) begin
                    failures++;
                    $display("FAIL %s: port%0d data=%h busy=%b, want data=%h busy=%b", e.name, e.port,
                             rd_data[e.port*DATA_W +: DATA_W], rd_busy[e.port], e.data, e.busy);
                end
            end
        end
    endtask

    task automatic test_reg0();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); idle();
            if (c == 0) begin
                we1 = 1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
                we0 = 1; wa0 = 5'd0; wd0 = 32'h1234;
                rsv_en = 1; rsv_addr = 5'd0;
            end
            set_rd(0, 0); set_rd(1, 0);
            push(0, 32'h0, 1'b0, "reg0_rd0");
            push(1, 32'h0, 1'b0, "reg0_rd1");
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); checks++;
                if (rd_data[e.port*DATA_W +: DATA_W] !== e.data || rd_busy[e.port] !== e.busy) begin
                    failures++;
                    $display("FAIL %s c=%0d: port%0d data=%h busy=%b, want data=%h busy=%b", e.name, c, e.port,
                             rd_data[e.port*DATA_W +: DATA_W], rd_busy[e.port], e.data, e.busy);
                end
            end
        end
    endtask

    task automatic test_scoreboard();
        exp_t e;
        // step: 0 reserve, 1 busy visible, 2 completing write, 3 cleared,
        //       4 reserve+write together, 5 busy still set
        for (int s = 0; s < 6; s++) begin
            @(negedge clk); idle();
            set_rd(0, 9); set_rd(1, 9);
            case (s)
                0: begin rsv_en = 1; rsv_addr = 5'd9; push(0, 32'h0, 1'b0, "sb_reserve"); end
                1: push(0, 32'h0, 1'b1, "sb_busy");
                2: begin we1 = 1; wa1 = 5'd9; wd1 = 32'h5A; push(0, 32'h5A, 1'b0, "sb_write_bypass"); end
                3: push(0, 32'h5A, 1'b0, "sb_cleared");
                4: begin
                    rsv_en = 1; rsv_addr = 5'd9; we1 = 1; wa1 = 5'd9; wd1 = 32'h77;
                    push(0, 32'h77, 1'b0, "sb_rsv_and_write");
                end
                default: push(0, 32'h77, 1'b1, "sb_set_wins");
            endcase
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); checks++;
                if (rd_data[e.port*DATA_W +: DATA_W] !== e.data || rd_busy[e.port] !== e.busy) begin
                    failures++;
                    $display("FAIL %s: port%0d data=%h busy=%b, want data=%h busy=%b", e.name, e.port,
                             rd_data[e.port*DATA_W +: DATA_W], rd_busy[e.port], e.data, e.busy);
                end
            end
        end
    endtask

    task automatic test_restart();
        exp_t e;
        @(negedge clk); idle(); we0 = 1; wa0 = 5'd20; wd0 = 32'hCAFE; rsv_en = 1; rsv_addr = 5'd12;
        @(negedge clk); idle(); rst = 1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++; $display("FAIL restart_async_ready: got %b want 0", ready);
        end
        @(negedge clk); rst = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ready !== 1'b0) begin
                failures++; $display("FAIL restart_partial_ready k=%0d: got %b want 0", k, ready);
            end
        end
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ready !== (k == DEPTH)) begin
                failures++; $display("FAIL restart_ready k=%0d: got %b want %b", k, ready, k == DEPTH);
            end
        end
        @(negedge clk); idle();
        set_rd(0, 20); set_rd(1, 12);
        push(0, 32'h0, 1'b0, "restart_reg20_cleared");
        push(1, 32'h0, 1'b0, "restart_reg12_not_busy");
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); checks++;
            if (rd_data[e.port*DATA_W +: DATA_W] !== e.data || rd_busy[e.port] !== e.busy) begin
                failures++;
                $display("FAIL %s: port%0d data=%h busy=%b, want data=%h busy=%b", e.name, e.port,
                         rd_data[e.port*DATA_W +: DATA_W], rd_busy[e.port], e.data, e.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] m [DEPTH];
        logic        b [DEPTH];
        int          a;
        logic [31:0] xd;
        logic        xb, c0, c1;
        for (int r = 0; r < DEPTH; r++) begin m[r] = '0; b[r] = 1'b0; end
        @(negedge clk); idle(); rst = 1;
        @(negedge clk); rst = 0;
        repeat (DEPTH) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1) begin
            failures++; $display("FAIL b2b_ready: got %b want 1", ready);
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            we0 = 1'($urandom_range(0, 1)); wa0 = ADDR_W'($urandom_range(0, 7)); wd0 = $urandom();
            we1 = 1'($urandom_range(0, 1)); wa1 = ADDR_W'($urandom_range(0, 7)); wd1 = $urandom();
            rsv_en = ($urandom_range(0, 3) == 0); rsv_addr = ADDR_W'($urandom_range(0, 7));
            for (int p = 0; p < NR_RD; p++) begin
                a = $urandom_range(0, 7);
                set_rd(p, a);
                c0 = we0 && (int'(wa0) == a);
                c1 = we1 && (int'(wa1) == a);
                if (a == 0)  begin xd = '0;  xb = 1'b0; end
                else begin
                    xd = c1 ? wd1 : c0 ? wd0 : m[a];
                    xb = b[a] && !(c0 || c1);
                end
                push(p, xd, xb, "b2b_read");
            end
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); checks++;
                if (rd_data[e.port*DATA_W +: DATA_W] !== e.data || rd_busy[e.port] !== e.busy) begin
                    failures++;
                    $display("FAIL %s cyc=%0d: port%0d data=%h busy=%b, want data=%h busy=%b", e.name, cyc, e.port,
                             rd_data[e.port*DATA_W +: DATA_W], rd_busy[e.port], e.data, e.busy);
                end
            end
            // Reference state update for the coming edge.
            if (we0 && wa0 != 0) m[wa0] = wd0;
            if (we1 && wa1 != 0) m[wa1] = wd1;
            for (int r = 1; r < DEPTH; r++) begin
                if (rsv_en && int'(rsv_addr) == r) b[r] = 1'b1;
                else if ((we0 && int'(wa0) == r) || (we1 && int'(wa1) == r)) b[r] = 1'b0;
            end
        end
        @(negedge clk); idle();
    endtask

    initial begin
        rd_addr = '0;
        test_reset();
        test_bypass();
        test_dual_write();
        test_reg0();
        test_scoreboard();
        test_restart();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
